// File: rtl/rx_os_decoder_pkg.sv
// rx_os_decoder_pkg: shared symbol constants, ordered-set type and K-symbol helper
package rx_os_decoder_pkg;
  localparam logic [7:0] K_COM  = 8'hBC;
  localparam logic [7:0] K_SKP  = 8'h1C;
  localparam logic [7:0] K_PAD  = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;
  typedef enum logic [1:0] {OS_NONE, OS_SKP, OS_TS1, OS_TS2} os_type_e;
  function automatic logic is_k(input logic [7:0] d, input logic k, input logic [7:0] s);
    return k && d == s;
  endfunction
endpackage

// File: rtl/rx_ts_cons_counter.sv
// rx_ts_cons_counter: counts consecutive identical TS sets, saturating, with one-shot hit
module rx_ts_cons_counter
  import rx_os_decoder_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MATCH_CNT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ts_done,
  input  os_type_e         ts_type,
  input  logic [39:0]      payload,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);
  logic             pv, same, sat, hit_n;
  os_type_e         pt;
  logic [39:0]      pp;
  logic [CNT_W-1:0] nxt;
  // next count: extend a run of identical sets, otherwise restart at one
  always_comb begin
    same  = pv && ts_type == pt && payload == pp;
    sat   = &cnt;
    nxt   = same ? (sat ? cnt : cnt + 1'b1) : CNT_W'(1);
    hit_n = ts_done && nxt == CNT_W'(MATCH_CNT) && !(same && sat);
  end
  // previous-set record, count and hit pulse
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      pv  <= 1'b0;
      pt  <= OS_NONE;
      pp  <= '0;
      cnt <= '0;
      hit <= 1'b0;
    end else begin
      hit <= hit_n;
      if (ts_done) begin
        cnt <= nxt;
        pv  <= 1'b1;
        pt  <= ts_type;
        pp  <= payload;
      end
    end
  end
endmodule

// File: rtl/rx_os_decoder.sv
// rx_os_decoder: COM-aligned SKP/TS1/TS2 ordered-set decoder with TS payload and run count
module rx_os_decoder
  import rx_os_decoder_pkg::*;
#(
  parameter int SKP_LEN   = 3,
  parameter int CNT_W     = 8,
  parameter int MATCH_CNT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_n,
  input  logic [7:0]       rxdata,
  input  logic             rxdatak,
  input  logic             rxvalid,
  output logic [39:0]      ts_payload,
  output logic             ts1_valid,
  output logic             ts2_valid,
  output logic             skp_valid,
  output logic             os_err,
  output logic [CNT_W-1:0] ts_cons_cnt,
  output logic             ts_cons_hit,
  output logic             sym_lock
);
  typedef enum logic [2:0] {ST_HUNT, ST_HDR, ST_SKP, ST_TSHDR, ST_TSID} state_e;
  state_e      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [2:0]  nskp, nskp_n;
  logic [7:0]  id, id_n;
  logic [39:0] shadow, shadow_n;
  logic        com, skp, done_skp, done_ts1, done_ts2, err;
  // next-state decode; bytes 1-5 shift in from the top so byte 1 lands in [7:0]
  always_comb begin
    com      = is_k(rxdata, rxdatak, K_COM);
    skp      = is_k(rxdata, rxdatak, K_SKP);
    state_n  = state;
    idx_n    = idx;
    nskp_n   = nskp;
    id_n     = id;
    shadow_n = shadow;
    done_skp = 1'b0;
    done_ts1 = 1'b0;
    done_ts2 = 1'b0;
    err      = 1'b0;
    if (rxvalid) begin
      case (state)
        ST_HUNT: begin
          state_n = com ? ST_HDR : ST_HUNT;
          idx_n   = com ? 4'd1 : idx;
        end
        ST_HDR: begin
          if (com) err = 1'b1;
          else if (skp) begin
            nskp_n   = 3'd1;
            done_skp = SKP_LEN == 1;
            state_n  = done_skp ? ST_HUNT : ST_SKP;
          end else begin
            shadow_n = {rxdata, shadow[39:8]};
            idx_n    = 4'd2;
            state_n  = ST_TSHDR;
          end
        end
        ST_SKP: begin
          if (skp) begin
            nskp_n   = nskp + 3'd1;
            done_skp = nskp_n == 3'(SKP_LEN);
            state_n  = done_skp ? ST_HUNT : ST_SKP;
          end else err = 1'b1;
        end
        ST_TSHDR: begin
          if (com) err = 1'b1;
          else begin
            shadow_n = {rxdata, shadow[39:8]};
            idx_n    = idx + 4'd1;
            state_n  = idx == 4'd5 ? ST_TSID : ST_TSHDR;
          end
        end
        ST_TSID: begin
          if (rxdatak || (idx == 4'd6 ? rxdata != TS1_ID && rxdata != TS2_ID : rxdata != id)) err = 1'b1;
          else begin
            id_n     = rxdata;
            idx_n    = idx + 4'd1;
            done_ts1 = idx == 4'd15 && id == TS1_ID;
            done_ts2 = idx == 4'd15 && id == TS2_ID;
            state_n  = idx == 4'd15 ? ST_HUNT : ST_TSID;
          end
        end
        default: state_n = ST_HUNT;
      endcase
      if (err) begin
        state_n = com ? ST_HDR : ST_HUNT;
        idx_n   = 4'd1;
      end
    end
  end
  // state and registered outputs; errors win over completion by construction
  always_ff @(posedge clk) begin
    if (!reset_n || en_n) begin
      state      <= ST_HUNT;
      idx        <= '0;
      nskp       <= '0;
      id         <= '0;
      shadow     <= '0;
      ts_payload <= '0;
      ts1_valid  <= 1'b0;
      ts2_valid  <= 1'b0;
      skp_valid  <= 1'b0;
      os_err     <= 1'b0;
      sym_lock   <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      nskp       <= nskp_n;
      id         <= id_n;
      shadow     <= shadow_n;
      ts1_valid  <= done_ts1;
      ts2_valid  <= done_ts2;
      skp_valid  <= done_skp;
      os_err     <= err;
      sym_lock   <= !err && (sym_lock || done_skp || done_ts1 || done_ts2);
      if (done_ts1 || done_ts2) ts_payload <= shadow;
    end
  end
  rx_ts_cons_counter #(.CNT_W(CNT_W), .MATCH_CNT(MATCH_CNT)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (err || en_n),
    .ts_done (done_ts1 || done_ts2),
    .ts_type (done_ts1 ? OS_TS1 : OS_TS2),
    .payload (shadow),
    .cnt     (ts_cons_cnt),
    .hit     (ts_cons_hit)
  );
endmodule

// File: tb/tb_rx_os_decoder.sv
// tb_rx_os_decoder: scoreboard bench for the ordered-set decoder
module tb_rx_os_decoder;
  import rx_os_decoder_pkg::*;
  localparam int MATCH = 8;
  localparam logic [39:0] P1 = 40'h00_02_FF_F7_F7;
  localparam logic [39:0] P2 = 40'h0F_05_80_03_11;
  logic        clk = 0, reset_n = 0, en_n = 0, rxdatak = 0, rxvalid = 0;
  logic [7:0]  rxdata = 0;
  logic [39:0] ts_payload;
  logic        ts1_valid, ts2_valid, skp_valid, os_err, ts_cons_hit, sym_lock;
  logic [7:0]  ts_cons_cnt;
  always #5 clk = ~clk;
  rx_os_decoder #(.SKP_LEN(3), .CNT_W(8), .MATCH_CNT(MATCH)) dut (
    .clk(clk), .reset_n(reset_n), .en_n(en_n), .rxdata(rxdata), .rxdatak(rxdatak), .rxvalid(rxvalid),
    .ts_payload(ts_payload), .ts1_valid(ts1_valid), .ts2_valid(ts2_valid), .skp_valid(skp_valid),
    .os_err(os_err), .ts_cons_cnt(ts_cons_cnt), .ts_cons_hit(ts_cons_hit), .sym_lock(sym_lock)
  );
  typedef struct packed {
    logic [3:0]  kind;
    logic [39:0] pay;
    logic [7:0]  cnt;
    logic        hit;
    logic        lock;
  } exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  int          errors = 0, checks = 0;
  logic        m_pv, m_lock;
  logic [7:0]  m_id, m_cnt;
  logic [39:0] m_pp, m_pay;
  // event monitor: every pulse is popped against the scoreboard
  always @(posedge clk) begin
    #1;
    if ({ts1_valid, ts2_valid, skp_valid, os_err} != 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind=%b cnt=%0d", {ts1_valid, ts2_valid, skp_valid, os_err}, ts_cons_cnt);
      end else begin
        e = exp_q.pop_front();
        if ({ts1_valid, ts2_valid, skp_valid, os_err} !== e.kind || ts_payload !== e.pay ||
            ts_cons_cnt !== e.cnt || ts_cons_hit !== e.hit || sym_lock !== e.lock) begin
          errors++;
          $display("FAIL event got kind=%b pay=%h cnt=%0d hit=%b lock=%b want kind=%b pay=%h cnt=%0d hit=%b lock=%b",
                   {ts1_valid, ts2_valid, skp_valid, os_err}, ts_payload, ts_cons_cnt, ts_cons_hit, sym_lock,
                   e.kind, e.pay, e.cnt, e.hit, e.lock);
        end
      end
    end else if (ts_cons_hit) begin
      checks++;
      errors++;
      $display("FAIL stray_hit got hit=1 want 0 cnt=%0d", ts_cons_cnt);
    end
  end
  task automatic model_reset();
    m_pv = 0; m_lock = 0; m_id = 0; m_cnt = 0; m_pp = 0; m_pay = 0;
  endtask
  task automatic push_ts(input logic [7:0] id, input logic [39:0] pay);
    logic hit;
    if (m_pv && m_id == id && m_pp == pay) begin
      hit   = m_cnt != 8'hFF && m_cnt + 8'd1 == 8'(MATCH);
      m_cnt = m_cnt == 8'hFF ? m_cnt : m_cnt + 8'd1;
    end else begin
      hit   = MATCH == 1;
      m_cnt = 8'd1;
    end
    m_pv = 1; m_id = id; m_pp = pay; m_pay = pay; m_lock = 1;
    exp_q.push_back({id == TS1_ID ? 4'b1000 : 4'b0100, m_pay, m_cnt, hit, 1'b1});
  endtask
  task automatic push_skp();
    m_lock = 1;
    exp_q.push_back({4'b0010, m_pay, m_cnt, 1'b0, 1'b1});
  endtask
  task automatic push_err();
    m_pv = 0; m_cnt = 0; m_lock = 0;
    exp_q.push_back({4'b0001, m_pay, 8'd0, 1'b0, 1'b0});
  endtask
  task automatic send(input logic [7:0] d, input logic k);
    @(negedge clk);
    rxdata = d; rxdatak = k; rxvalid = 1;
    @(posedge clk);
    #1 rxvalid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxvalid = 0; rxdata = 8'($urandom); rxdatak = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_skp();
    push_skp();
    send(K_COM, 1);
    repeat (3) send(K_SKP, 1);
  endtask
  task automatic send_ts(input logic [7:0] id, input logic [39:0] pay, input int first_j = 0, input int bad_j = -1,
                         input logic [7:0] bad_d = 0, input logic bad_k = 0, input int stall_j = -1, input int stall_n = 0);
    logic [7:0] b;
    for (int j = first_j; j < 16; j++) begin
      if (j == bad_j) begin
        push_err();
        send(bad_d, bad_k);
        return;
      end
      b = j == 0 ? K_COM : j <= 5 ? pay[8*(j-1) +: 8] : id;
      if (j == 15) push_ts(id, pay);
      send(b, j == 0 || (j <= 5 && b == K_PAD));
      if (j == stall_j) idle(stall_n);
    end
  endtask
  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ts_payload !== 40'd0) begin errors++; $display("FAIL reset_payload got %h want 0", ts_payload); end
    checks++; if ({ts1_valid, ts2_valid, skp_valid, os_err} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {ts1_valid, ts2_valid, skp_valid, os_err}); end
    checks++; if (ts_cons_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ts_cons_cnt); end
    checks++; if (ts_cons_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", ts_cons_hit); end
    checks++; if (sym_lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", sym_lock); end
    reset_n = 1;
    model_reset();
  endtask
  task automatic test_skp();
    send(TS1_ID, 0);
    send(K_SKP, 1);
    send(K_PAD, 1);
    push_skp();
    send(K_COM, 1);
    repeat (3) send(K_SKP, 1);
    checks++; if (ts_payload !== 40'd0) begin errors++; $display("FAIL skp_payload got %h want 0", ts_payload); end
    checks++; if (sym_lock !== 1'b1) begin errors++; $display("FAIL skp_lock got %b want 1", sym_lock); end
    send(K_COM, 1);
    send(K_SKP, 1);
    push_err();
    send(8'h00, 0);
    send_skp();
  endtask
  task automatic test_ts1();
    send_ts(TS1_ID, P1);
    checks++; if (ts_payload !== P1) begin errors++; $display("FAIL ts1_payload got %h want %h", ts_payload, P1); end
    checks++; if (ts_cons_cnt !== 8'd1) begin errors++; $display("FAIL ts1_cnt got %0d want 1", ts_cons_cnt); end
  endtask
  task automatic test_back_to_back();
    repeat (8) send_ts(TS1_ID, P1);
    checks++; if (ts_cons_cnt !== 8'd9) begin errors++; $display("FAIL b2b_cnt got %0d want 9", ts_cons_cnt); end
  endtask
  task automatic test_error();
    send_ts(TS1_ID, P1, 0, 10, TS2_ID, 0);
    checks++; if (ts_cons_cnt !== 8'd0 || sym_lock !== 1'b0) begin errors++; $display("FAIL err_state got cnt=%0d lock=%b want cnt=0 lock=0", ts_cons_cnt, sym_lock); end
    send_ts(TS1_ID, P1);
    send_skp();
    send_ts(TS1_ID, P1);
    checks++; if (ts_cons_cnt !== 8'd2) begin errors++; $display("FAIL skp_interleave_cnt got %0d want 2", ts_cons_cnt); end
  endtask
  task automatic test_stall_com();
    send_ts(TS2_ID, P2, 0, -1, 0, 0, 7, 3);
    checks++; if (ts_payload !== P2) begin errors++; $display("FAIL stall_payload got %h want %h", ts_payload, P2); end
    send_ts(TS2_ID, P2, 0, 9, K_COM, 1);
    send_ts(TS2_ID, P2, 1);
    checks++; if (ts_cons_cnt !== 8'd1) begin errors++; $display("FAIL com_restart_cnt got %0d want 1", ts_cons_cnt); end
  endtask
  task automatic test_mid_reset();
    for (int v = 0; v < 2; v++) begin
      send(K_COM, 1);
      for (int j = 1; j < 8; j++) send(j <= 5 ? P1[8*(j-1) +: 8] : TS1_ID, j <= 2);
      @(negedge clk);
      if (v == 0) reset_n = 0; else en_n = 1;
      @(posedge clk);
      #1;
      checks++;
      if ({ts_payload, ts1_valid, ts2_valid, skp_valid, os_err, ts_cons_cnt, ts_cons_hit, sym_lock} !== 54'd0) begin
        errors++;
        $display("FAIL midreset_%0d got pay=%h cnt=%0d lock=%b want all 0", v, ts_payload, ts_cons_cnt, sym_lock);
      end
      reset_n = 1; en_n = 0;
      model_reset();
      send_ts(TS1_ID, P1);
      checks++; if (ts_cons_cnt !== 8'd1) begin errors++; $display("FAIL midreset_%0d_cnt got %0d want 1", v, ts_cons_cnt); end
    end
  endtask
  initial begin
    test_reset();
    test_skp();
    test_ts1();
    test_back_to_back();
    test_error();
    test_stall_com();
    test_mid_reset();
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
